// File: rtl/difficulty_menu_ctrl.sv
// Difficulty-selection menu sequencer: scroll a pending level, confirm it through the popup, then commit and start the game.
// Optional build macro MENU_TIMEOUT_EN adds a popup wait timeout of TIMEOUT_CYCLES clocks (treated as cancel).
module difficulty_menu_ctrl #(
    parameter int NUM_LEVELS     = 4,
    parameter int LEVEL_W        = 4,
    parameter int DEFAULT_LEVEL  = 0,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_select,
    input  logic               btn_back,
    input  logic               popup_confirmed,
    input  logic               popup_canceled,
    output logic               popup_activate,
    output logic [15:0]        popup_msg,
    output logic [LEVEL_W-1:0] pending_level,
    output logic [LEVEL_W-1:0] level,
    output logic               level_valid,
    output logic               game_start,
    output logic               busy,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_SELECT = 3'd0,
        S_ASK    = 3'd1,
        S_WAIT   = 3'd2,
        S_COMMIT = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LEVEL_W-1:0] RST_LEVEL = LEVEL_W'(DEFAULT_LEVEL);

    // Button vector order: 0=up, 1=down, 2=select, 3=back
    localparam int BTN_UP  = 0;
    localparam int BTN_DN  = 1;
    localparam int BTN_SEL = 2;
    localparam int BTN_BK  = 3;

    state_t             state_reg, state_next;
    logic [LEVEL_W-1:0] pending_level_reg, pending_level_next;
    logic [LEVEL_W-1:0] level_reg, level_next;
    logic [3:0]         btn_now, btn_prev_reg, btn_edge;
    logic               timeout_hit;

    assign btn_now = {btn_back, btn_select, btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            assign btn_edge[gi] = btn_now[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

`ifdef MENU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] timeout_cnt_reg;

    // Cleared while in ASK so the count starts at zero on the first WAIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == S_ASK) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == S_WAIT) begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == S_WAIT) &&
                         (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= S_SELECT;
            pending_level_reg <= RST_LEVEL;
            level_reg         <= RST_LEVEL;
            btn_prev_reg      <= '1;
        end else begin
            state_reg         <= state_next;
            pending_level_reg <= pending_level_next;
            level_reg         <= level_next;
            btn_prev_reg      <= btn_now;
        end
    end

    always_comb begin
        state_next         = state_reg;
        pending_level_next = pending_level_reg;
        level_next         = level_reg;
        case (state_reg)
            S_SELECT: begin
                if (btn_edge[BTN_SEL]) begin
                    state_next = S_ASK;
                end else if (btn_edge[BTN_UP] && !btn_edge[BTN_DN]) begin
                    if (pending_level_reg != MAX_LEVEL)
                        pending_level_next = pending_level_reg + 1'b1;
                end else if (btn_edge[BTN_DN] && !btn_edge[BTN_UP]) begin
                    if (pending_level_reg != '0)
                        pending_level_next = pending_level_reg - 1'b1;
                end
            end
            S_ASK: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // Cancel beats confirm; a real response beats the timeout
                if (popup_canceled) begin
                    state_next = S_SELECT;
                end else if (popup_confirmed) begin
                    state_next = S_COMMIT;
                    level_next = pending_level_reg;
                end else if (timeout_hit) begin
                    state_next = S_SELECT;
                end
            end
            S_COMMIT: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (btn_edge[BTN_BK])
                    state_next = S_SELECT;
            end
            default: begin
                state_next = S_SELECT;
            end
        endcase
    end

    // Outputs are decodes of the state register, so each pulse lasts exactly one state
    assign popup_activate = (state_reg == S_ASK);
    assign game_start     = (state_reg == S_COMMIT);
    assign level_valid    = (state_reg == S_RUN);
    assign busy           = (state_reg == S_ASK) || (state_reg == S_WAIT) ||
                            (state_reg == S_COMMIT);
    assign state_dbg      = state_reg;
    assign pending_level  = pending_level_reg;
    assign level          = level_reg;
    assign popup_msg      = {8'hD1, 8'(pending_level_reg)};

endmodule

// File: tb/tb_difficulty_menu_ctrl.sv
// Directed self-checking bench for difficulty_menu_ctrl (NUM_LEVELS=4, TIMEOUT_CYCLES=8).
module tb_difficulty_menu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_up, btn_down, btn_select, btn_back;
    logic        popup_confirmed, popup_canceled;
    logic        popup_activate;
    logic [15:0] popup_msg;
    logic [3:0]  pending_level, level;
    logic        level_valid, game_start, busy;
    logic [2:0]  state_dbg;

    int tests_run = 0;
    int tests_failed = 0;
    int start_count = 0;
    int n;

    difficulty_menu_ctrl #(
        .NUM_LEVELS(4), .LEVEL_W(4), .DEFAULT_LEVEL(0), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_select(btn_select), .btn_back(btn_back),
        .popup_confirmed(popup_confirmed), .popup_canceled(popup_canceled),
        .popup_activate(popup_activate), .popup_msg(popup_msg),
        .pending_level(pending_level), .level(level), .level_valid(level_valid),
        .game_start(game_start), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && game_start) start_count <= start_count + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic press_up();
        btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
    endtask

    task automatic press_down();
        btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b1;
        btn_up = 1'b1; btn_down = 1'b0; btn_select = 1'b0; btn_back = 1'b0;
        popup_confirmed = 1'b0; popup_canceled = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(state_dbg), 0);
        chk("rst_pending", 32'(pending_level), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_msg", 32'(popup_msg), 32'hD100);
        chk("rst_flags", {28'd0, popup_activate, game_start, level_valid, busy}, 0);

        // Held up through reset must not count as a press
        rst = 1'b0;
        tick(); tick();
        chk("held_up_no_edge", 32'(pending_level), 0);
        btn_up = 1'b0; tick();

        press_up();
        chk("up_once", 32'(pending_level), 1);
        for (int i = 0; i < 4; i++) press_up();
        chk("up_saturate", 32'(pending_level), 3);
        for (int i = 0; i < 4; i++) press_down();
        chk("down_saturate", 32'(pending_level), 0);

        // Simultaneous up/down edges cancel each other
        btn_up = 1'b1; btn_down = 1'b1; tick();
        chk("up_down_same", 32'(pending_level), 0);
        btn_up = 1'b0; btn_down = 1'b0; tick();

        press_up(); press_up();
        chk("pending_two", 32'(pending_level), 2);

        btn_select = 1'b1; tick();
        chk("ask_state", 32'(state_dbg), 1);
        chk("ask_activate", 32'(popup_activate), 1);
        chk("ask_msg", 32'(popup_msg), 32'hD102);
        chk("ask_busy", 32'(busy), 1);
        btn_select = 1'b0; tick();
        chk("wait_state", 32'(state_dbg), 2);
        chk("activate_one_cycle", 32'(popup_activate), 0);
        chk("wait_busy", 32'(busy), 1);

        press_up(); press_up(); press_down();
        chk("wait_pending_frozen", 32'(pending_level), 2);
        chk("wait_still", 32'(state_dbg), 2);

        popup_confirmed = 1'b1; tick();
        chk("commit_start", 32'(game_start), 1);
        chk("commit_level", 32'(level), 2);
        chk("commit_state", 32'(state_dbg), 3);
        popup_confirmed = 1'b0; tick();
        chk("run_start_clear", 32'(game_start), 0);
        chk("run_valid", 32'(level_valid), 1);
        chk("run_state", 32'(state_dbg), 4);
        chk("run_busy", 32'(busy), 0);

        press_up();
        btn_select = 1'b1; tick(); btn_select = 1'b0; tick();
        chk("run_ignore_btns", 32'(state_dbg), 4);
        chk("run_pending", 32'(pending_level), 2);

        btn_back = 1'b1; tick();
        chk("back_state", 32'(state_dbg), 0);
        chk("back_valid", 32'(level_valid), 0);
        chk("back_level_kept", 32'(level), 2);
        btn_back = 1'b0; tick();

        press_down();
        chk("pending_one", 32'(pending_level), 1);

        // Select wins over a same-cycle up edge
        btn_select = 1'b1; btn_up = 1'b1; tick();
        chk("sel_prio_state", 32'(state_dbg), 1);
        chk("sel_prio_pending", 32'(pending_level), 1);
        btn_select = 1'b0; btn_up = 1'b0; tick();
        popup_confirmed = 1'b1; popup_canceled = 1'b1; tick();
        chk("both_cancel_state", 32'(state_dbg), 0);
        chk("both_cancel_level", 32'(level), 2);
        chk("both_cancel_pending", 32'(pending_level), 1);
        chk("both_cancel_nostart", 32'(game_start), 0);
        popup_confirmed = 1'b0; popup_canceled = 1'b0; tick();

`ifdef MENU_TIMEOUT_EN
        btn_select = 1'b1; tick(); btn_select = 1'b0; tick();
        n = 0;
        while (state_dbg == 3'd2 && n < 20) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 8);
        chk("timeout_state", 32'(state_dbg), 0);
        chk("timeout_pending", 32'(pending_level), 1);
`endif

        // Reset in the middle of WAIT
        btn_select = 1'b1; tick(); btn_select = 1'b0; tick();
        chk("pre_rst_wait", 32'(state_dbg), 2);
        rst = 1'b1; tick();
        chk("midwait_rst_state", 32'(state_dbg), 0);
        chk("midwait_rst_pending", 32'(pending_level), 0);
        chk("midwait_rst_level", 32'(level), 0);
        chk("midwait_rst_valid", 32'(level_valid), 0);
        rst = 1'b0; tick(); tick();
        chk("after_rst_state", 32'(state_dbg), 0);

        chk("game_start_count", 32'(start_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
